// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the
// multi-cycle control sequencer.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH_HI,
    S_FETCH_LO,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_MEM = 2'b01;
  localparam logic [1:0] CLS_LDI = 2'b10;
  localparam logic [1:0] CLS_CTL = 2'b11;

  localparam logic [4:0] OP_BRZ  = 5'b00000;
  localparam logic [4:0] OP_JMP  = 5'b10000;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam logic [4:0] FS_PASS_B = 5'b01100;

  localparam int CLS_HI = 15;
  localparam int CLS_LO = 14;
  localparam int FS_HI  = 13;
  localparam int FS_LO  = 9;
  localparam int DR_HI  = 8;
  localparam int DR_LO  = 6;
  localparam int SA_HI  = 5;
  localparam int SA_LO  = 3;
  localparam int SB_HI  = 2;
  localparam int SB_LO  = 0;
  localparam int ST_BIT = 9;

  typedef struct packed {
    logic [2:0] dr;
    logic [2:0] sa;
    logic [2:0] sb;
    logic [4:0] fs;
    logic       mb;
    logic       alu_wr;
    logic       mem_op;
    logic       ld;
    logic       st;
    logic       brz;
    logic       jmp;
    logic       halt;
  } dec_t;

endpackage

// File: rtl/cpu_decoder.sv
// cpu_decoder: combinational instruction decode
// from ir to selects, strobes and next-state hints.
module cpu_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output dec_t        dec
);

  logic [1:0] cls;
  logic [4:0] op;

  assign cls = ir[CLS_HI:CLS_LO];
  assign op  = ir[FS_HI:FS_LO];

  // Split the instruction into fields and class flags.
  always_comb begin
    dec    = '0;
    dec.dr = ir[DR_HI:DR_LO];
    dec.sa = ir[SA_HI:SA_LO];
    dec.sb = ir[SB_HI:SB_LO];
    dec.fs = op;
    unique case (cls)
      CLS_ALU: dec.alu_wr = 1'b1;
      CLS_MEM: begin
        dec.mem_op = 1'b1;
        dec.st     = ir[ST_BIT];
        dec.ld     = !ir[ST_BIT];
      end
      CLS_LDI: begin
        dec.alu_wr = 1'b1;
        dec.mb     = 1'b1;
        dec.fs     = FS_PASS_B;
      end
      default: begin
        dec.brz  = (op == OP_BRZ);
        dec.jmp  = (op == OP_JMP);
        dec.halt = (op == OP_HALT);
      end
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: two-byte fetch, decode and
// multi-cycle control for the 8-bit CPU.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_ready,
  input  logic [7:0]        mem_rdata,
  input  logic [7:0]        ra_data,
  input  logic              zero,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       ir,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mw,
  output logic [2:0]        dr,
  output logic [2:0]        sa,
  output logic [2:0]        sb,
  output logic [4:0]        fs,
  output logic              mb,
  output logic              md,
  output logic              rw
);

  state_t            state;
  dec_t              dec;
  logic [5:0]        off;
  logic [ADDR_W-1:0] boff;
  logic [ADDR_W-1:0] ra_addr;
  logic              in_fetch;
  logic              in_mem;
  logic              in_exec;

  cpu_decoder u_dec (
    .ir  (ir),
    .dec (dec)
  );

  assign off     = {ir[DR_HI:DR_LO], ir[SB_HI:SB_LO]};
  assign boff    = {{(ADDR_W-6){off[5]}}, off};
  assign ra_addr = ADDR_W'(ra_data);

  assign in_fetch = (state == S_FETCH_HI) ||
                    (state == S_FETCH_LO);
  assign in_mem   = (state == S_MEM);
  assign in_exec  = (state == S_EXEC);

  assign dr = dec.dr;
  assign sa = dec.sa;
  assign sb = dec.sb;
  assign fs = dec.fs;
  assign mb = dec.mb;

  assign mem_req  = !reset && (in_fetch || in_mem);
  assign mem_addr = in_mem ? ra_addr : pc;
  assign mw       = !reset && in_mem && dec.st;
  assign md       = !reset && in_mem && dec.ld &&
                    mem_ready;
  assign rw       = !reset &&
                    ((in_exec && dec.alu_wr) ||
                     (in_mem && dec.ld && mem_ready));

  // Control FSM owning state, pc and ir.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH_HI;
      pc    <= RESET_PC;
      ir    <= '0;
    end else begin
      unique case (state)
        S_FETCH_HI: begin
          if (mem_ready) begin
            ir[15:8] <= mem_rdata;
            pc       <= pc + ADDR_W'(1);
            state    <= S_FETCH_LO;
          end
        end
        S_FETCH_LO: begin
          if (mem_ready) begin
            ir[7:0] <= mem_rdata;
            pc      <= pc + ADDR_W'(1);
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (dec.halt) begin
            state <= S_HALT;
          end else if (dec.mem_op) begin
            state <= S_MEM;
          end else begin
            state <= S_FETCH_HI;
          end
          if (dec.brz && zero) begin
            pc <= pc + boff;
          end
          if (dec.jmp) begin
            pc <= ra_addr;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            state <= S_FETCH_HI;
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed vectors and
// hand sequences for the control sequencer.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mem_ready = 1'b1;
  logic [7:0] mem_rdata;
  logic [7:0] ra_data = 8'h00;
  logic       zero = 1'b0;
  logic [7:0] pc;
  logic [15:0] ir;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mw;
  logic [2:0] dr, sa, sb;
  logic [4:0] fs;
  logic       mb, md, rw;

  logic [7:0] mem [256];

  int n_run = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  pc_at;
    logic [7:0]  ra;
    logic        zero;
    logic [2:0]  dr;
    logic [2:0]  sa;
    logic [2:0]  sb;
    logic [4:0]  fs;
    logic        mb;
    logic        rw_ex;
    logic        memop;
    logic        mw;
    logic        ld;
    logic [7:0]  nxt;
  } vec_t;

  vec_t vecs [10];

  cpu_sequencer #(
    .ADDR_W   (8),
    .RESET_PC (8'h00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .ra_data   (ra_data),
    .zero      (zero),
    .pc        (pc),
    .ir        (ir),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mw        (mw),
    .dr        (dr),
    .sa        (sa),
    .sb        (sb),
    .fs        (fs),
    .mb        (mb),
    .md        (md),
    .rw        (rw)
  );

  assign mem_rdata = mem[mem_addr];

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    logic [7:0] a1;
    logic [7:0] ex_pc;
    string p;
    p = $sformatf("v%0d", i);
    a1 = v.pc_at + 8'd1;
    ex_pc = v.pc_at + 8'd2;
    mem_ready = 1'b1;
    zero = 1'b0;
    pulse_reset();
    mem[0] = 8'hE0;
    mem[1] = 8'h00;
    ra_data = v.pc_at;
    repeat (3) @(negedge clk);
    mem[v.pc_at] = v.instr[15:8];
    mem[a1] = v.instr[7:0];
    ra_data = v.ra;
    zero = v.zero;
    #1;
    chk({p, "_f1req"}, mem_req, 1);
    chk({p, "_f1addr"}, mem_addr, v.pc_at);
    @(negedge clk);
    chk({p, "_f2addr"}, mem_addr, a1);
    chk({p, "_f2rw"}, rw, 0);
    @(negedge clk);
    chk({p, "_exreq"}, mem_req, 0);
    chk({p, "_exrw"}, rw, v.rw_ex);
    chk({p, "_exmw"}, mw, 0);
    chk({p, "_expc"}, pc, ex_pc);
    chk({p, "_dr"}, dr, v.dr);
    chk({p, "_sa"}, sa, v.sa);
    chk({p, "_sb"}, sb, v.sb);
    chk({p, "_fs"}, fs, v.fs);
    chk({p, "_mb"}, mb, v.mb);
    if (v.memop) begin
      @(negedge clk);
      chk({p, "_mreq"}, mem_req, 1);
      chk({p, "_maddr"}, mem_addr, v.ra);
      chk({p, "_mw"}, mw, v.mw);
      chk({p, "_mrw"}, rw, v.ld);
      chk({p, "_md"}, md, v.ld);
    end
    @(negedge clk);
    chk({p, "_nreq"}, mem_req, 1);
    chk({p, "_naddr"}, mem_addr, v.nxt);
    chk({p, "_npc"}, pc, v.nxt);
    chk({p, "_nrw"}, rw, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    vecs[0] = '{16'h0A5E, 8'h20, 8'h00, 1'b0,
      3'd1, 3'd3, 3'd6, 5'h05,
      1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22};
    vecs[1] = '{16'h9A05, 8'h30, 8'h00, 1'b0,
      3'd0, 3'd0, 3'd5, 5'h0C,
      1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h32};
    vecs[2] = '{16'h4000, 8'h40, 8'h80, 1'b0,
      3'd0, 3'd0, 3'd0, 5'h00,
      1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h42};
    vecs[3] = '{16'h4211, 8'h50, 8'h90, 1'b0,
      3'd0, 3'd2, 3'd1, 5'h01,
      1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h52};
    vecs[4] = '{16'hC1C6, 8'h10, 8'h00, 1'b1,
      3'd7, 3'd0, 3'd6, 5'h00,
      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10};
    vecs[5] = '{16'hC1C6, 8'h10, 8'h00, 1'b0,
      3'd7, 3'd0, 3'd6, 5'h00,
      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12};
    vecs[6] = '{16'hE000, 8'hFF, 8'h40, 1'b0,
      3'd0, 3'd0, 3'd0, 5'h10,
      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h40};
    vecs[7] = '{16'hC200, 8'h60, 8'h00, 1'b1,
      3'd0, 3'd0, 3'd0, 5'h01,
      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h62};
    vecs[8] = '{16'hC005, 8'h70, 8'h00, 1'b1,
      3'd0, 3'd0, 3'd5, 5'h00,
      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77};
    vecs[9] = '{16'hC1C0, 8'h02, 8'h00, 1'b1,
      3'd7, 3'd0, 3'd0, 5'h00,
      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFC};

    // reset values, then first fetch from 0x00
    reset = 1'b1;
    @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_pc", pc, 8'h00);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_rw", rw, 0);
    chk("rst_mw", mw, 0);
    chk("rst_md", md, 0);
    chk("rst_mb", mb, 0);
    chk("rst_fs", fs, 0);
    reset = 1'b0;
    #1;
    chk("s0_f1req", mem_req, 1);
    chk("s0_f1addr", mem_addr, 8'h00);
    @(negedge clk);
    chk("s0_f2addr", mem_addr, 8'h01);
    chk("s0_f2rw", rw, 0);
    @(negedge clk);
    chk("s0_exrw", rw, 1);
    @(negedge clk);
    chk("s0_pc", pc, 8'h02);
    chk("s0_rw_once", rw, 0);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // LD with two wait cycles in MEM
    mem_ready = 1'b1;
    zero = 1'b0;
    pulse_reset();
    mem[0] = 8'h40;
    mem[1] = 8'h00;
    ra_data = 8'h80;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      mem_ready = 1'b0;
      #1;
      chk($sformatf("ld_w%0d_req", k), mem_req, 1);
      chk($sformatf("ld_w%0d_addr", k), mem_addr, 8'h80);
      chk($sformatf("ld_w%0d_mw", k), mw, 0);
      chk($sformatf("ld_w%0d_rw", k), rw, 0);
      chk($sformatf("ld_w%0d_md", k), md, 0);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    chk("ld_rdy_rw", rw, 1);
    chk("ld_rdy_md", md, 1);
    @(negedge clk);
    chk("ld_next_addr", mem_addr, 8'h02);
    chk("ld_next_rw", rw, 0);

    // fetch wait, then HALT absorbs
    pulse_reset();
    mem[0] = 8'hFE;
    mem[1] = 8'h00;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("fw_req", mem_req, 1);
    chk("fw_addr", mem_addr, 8'h00);
    chk("fw_pc", pc, 8'h00);
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("halt%0d_req", k), mem_req, 0);
      chk($sformatf("halt%0d_rw", k), rw, 0);
      chk($sformatf("halt%0d_pc", k), pc, 8'h02);
      @(negedge clk);
    end

    // reset in the middle of a stalled ST
    pulse_reset();
    mem[0] = 8'h42;
    mem[1] = 8'h11;
    ra_data = 8'h90;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("st_mw", mw, 1);
    chk("st_req", mem_req, 1);
    chk("st_addr", mem_addr, 8'h90);
    #1;
    reset = 1'b1;
    #1;
    chk("st_rst_mw", mw, 0);
    chk("st_rst_req", mem_req, 0);
    chk("st_rst_rw", rw, 0);
    chk("st_rst_pc", pc, 8'h00);
    @(negedge clk);
    mem[0] = 8'h00;
    mem[1] = 8'h00;
    mem_ready = 1'b1;
    reset = 1'b0;
    #1;
    chk("st_resume_req", mem_req, 1);
    chk("st_resume_addr", mem_addr, 8'h00);
    @(negedge clk);
    chk("st_resume_f2", mem_addr, 8'h01);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
